// File: rtl/reg_bank_param.sv
// reg_bank_param: DATA_W x DEPTH register bank, two combinational read ports,
// one synchronous write port, hardwired zero register (ZERO_REG), out-of-range
// masking and a sequenced bulk clear reported on BUSY.
// Optional macro BANKREG_BYPASS_EN: same-cycle write-to-read forwarding.
module reg_bank_param #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] AR1,
  input  logic [ADDR_W-1:0] AR2,
  input  logic [ADDR_W-1:0] AW,
  input  logic              REG_WRITE,
  input  logic [DATA_W-1:0] DATAIN,
  input  logic              CLEAR,
  output logic [DATA_W-1:0] DR1,
  output logic [DATA_W-1:0] DR2,
  output logic              BUSY
);

  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_idle;
  logic              w_cnt_last;
  logic              w_wr_ok;
  logic [DATA_W-1:0] w_dr1;
  logic [DATA_W-1:0] w_dr2;

  // An address names real storage only if it is inside the array and is not
  // the hardwired zero register; reads and writes share this rule.
  function automatic logic f_addr_ok(input logic [ADDR_W-1:0] a);
    return (int'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign w_cnt_last = (int'(r_cnt) == DEPTH - 1);
  assign w_wr_ok    = w_idle && REG_WRITE && f_addr_ok(AW);

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next state: a clear request starts a sweep, the last entry ends it.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (CLEAR)      w_next_state = SWEEP;
      SWEEP:   if (w_cnt_last) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    w_idle = (r_state == IDLE);
    BUSY   = (r_state == SWEEP);
  end

  // Sweep pointer: advances once per sweep edge and rests at 0 otherwise.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                                r_cnt <= '0;
    else if (r_state == SWEEP && !w_cnt_last) r_cnt <= r_cnt + ADDR_W'(1);
    else                                    r_cnt <= '0;
  end

  // Storage: the sweep owns the array while active, so writes then are lost.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (r_state == SWEEP) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr_ok) begin
      r_mem[AW] <= DATAIN;
    end
  end

  // Read muxes; with forwarding, a write actually being performed this cycle
  // overrides the stored value on a matching port.
  always_comb begin
    w_dr1 = f_addr_ok(AR1) ? r_mem[AR1] : '0;
    w_dr2 = f_addr_ok(AR2) ? r_mem[AR2] : '0;
`ifdef BANKREG_BYPASS_EN
    if (w_wr_ok && (AW == AR1)) w_dr1 = DATAIN;
    if (w_wr_ok && (AW == AR2)) w_dr2 = DATAIN;
`endif
  end

  assign DR1 = w_dr1;
  assign DR2 = w_dr2;

endmodule
